// File: rtl/i2c_target_responder.sv
// I2C target with an auto-incrementing byte register bank; SCL/SDA are oversampled on clk.
// SDA changes within 3 clk of a synchronized SCL fall; no backpressure, SCL is never stretched.
module i2c_target_responder #(
  parameter logic [6:0] slaveAddress = 7'h39,
  parameter int         regCount     = 16,
  parameter int         ptrWidth     = 4
) (
  input  logic                clk,
  input  logic                reset,
  inout  wire                 SCL,
  inout  wire                 SDA,
  input  logic [ptrWidth-1:0] regSel,
  output logic [7:0]          regValue,
  output logic                writeStrobe,
  output logic [ptrWidth-1:0] writeAddr,
  output logic [7:0]          writeData,
  output logic                busy
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_IGNORE,
    ST_PTR,
    ST_PTR_ACK,
    ST_WRITE,
    ST_WRITE_ACK,
    ST_READ,
    ST_READ_ACK
  } state_t;

  localparam logic [ptrWidth-1:0] ptr_one = ptrWidth'(1);

  state_t              state, state_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic [7:0]          shreg, shreg_nxt;
  logic [ptrWidth-1:0] ptr, ptr_nxt;
  logic                sda_oe, sda_oe_nxt;
  logic                rw, rw_nxt;
  logic                busy_nxt;
  logic                wr_en;

  logic                scl_s1, scl_s2, scl_d;
  logic                sda_s1, sda_s2, sda_d;
  logic                scl_rise, scl_fall, bus_start, bus_stop;
  logic [7:0]          rx_byte, rd_byte;
  logic [7:0]          reg_bank [regCount];

  // Synchronizers reset to the idle-bus level so reset release never fakes an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= SCL;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= SDA;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign bus_start = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign bus_stop  = scl_s2 & scl_d & ~sda_d & sda_s2;

  assign rx_byte  = {shreg[6:0], sda_s2};
  assign rd_byte  = reg_bank[ptr];
  assign regValue = reg_bank[regSel];
  assign SDA      = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      shreg  <= '0;
      ptr    <= '0;
      sda_oe <= 1'b0;
      rw     <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      shreg  <= shreg_nxt;
      ptr    <= ptr_nxt;
      sda_oe <= sda_oe_nxt;
      rw     <= rw_nxt;
      busy   <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    shreg_nxt  = shreg;
    ptr_nxt    = ptr;
    sda_oe_nxt = sda_oe;
    rw_nxt     = rw;
    busy_nxt   = busy;
    wr_en      = 1'b0;

    unique case (state)
      ST_IDLE, ST_IGNORE: begin
      end
      ST_ADDR: begin
        if (scl_rise) begin
          shreg_nxt = rx_byte;
          cnt_nxt   = cnt + 4'd1;
          if (cnt == 4'd7) begin
            cnt_nxt = '0;
            rw_nxt  = sda_s2;
            if (shreg[6:0] == slaveAddress) begin
              state_nxt = ST_ADDR_ACK;
              busy_nxt  = 1'b1;
            end else begin
              state_nxt = ST_IGNORE;
              busy_nxt  = 1'b0;
            end
          end
        end
      end
      // First SCL fall after bit 8 starts the ACK, the second ends it.
      ST_ADDR_ACK: begin
        if (scl_fall) begin
          if (!sda_oe) begin
            sda_oe_nxt = 1'b1;
          end else if (rw) begin
            shreg_nxt  = rd_byte;
            sda_oe_nxt = ~rd_byte[7];
            state_nxt  = ST_READ;
          end else begin
            sda_oe_nxt = 1'b0;
            state_nxt  = ST_PTR;
          end
        end
      end
      ST_PTR: begin
        if (scl_rise) begin
          shreg_nxt = rx_byte;
          cnt_nxt   = cnt + 4'd1;
          if (cnt == 4'd7) begin
            cnt_nxt   = '0;
            ptr_nxt   = rx_byte[ptrWidth-1:0];
            state_nxt = ST_PTR_ACK;
          end
        end
      end
      ST_PTR_ACK, ST_WRITE_ACK: begin
        if (scl_fall) begin
          if (!sda_oe) begin
            sda_oe_nxt = 1'b1;
          end else begin
            sda_oe_nxt = 1'b0;
            state_nxt  = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (scl_rise) begin
          shreg_nxt = rx_byte;
          cnt_nxt   = cnt + 4'd1;
          if (cnt == 4'd7) begin
            cnt_nxt   = '0;
            wr_en     = 1'b1;
            ptr_nxt   = ptr + ptr_one;
            state_nxt = ST_WRITE_ACK;
          end
        end
      end
      ST_READ: begin
        if (scl_rise && cnt != 4'd8) begin
          cnt_nxt = cnt + 4'd1;
        end else if (scl_fall) begin
          if (cnt == 4'd8) begin
            cnt_nxt    = '0;
            sda_oe_nxt = 1'b0;
            ptr_nxt    = ptr + ptr_one;
            state_nxt  = ST_READ_ACK;
          end else begin
            sda_oe_nxt = ~shreg[6];
            shreg_nxt  = {shreg[6:0], 1'b0};
          end
        end
      end
      // cnt == 1 marks that the initiator acknowledged on the 9th rise.
      ST_READ_ACK: begin
        if (scl_rise) begin
          if (sda_s2) begin
            state_nxt = ST_IDLE;
            busy_nxt  = 1'b0;
          end else begin
            cnt_nxt = 4'd1;
          end
        end else if (scl_fall && cnt == 4'd1) begin
          cnt_nxt    = '0;
          shreg_nxt  = rd_byte;
          sda_oe_nxt = ~rd_byte[7];
          state_nxt  = ST_READ;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (bus_start) begin
      state_nxt  = ST_ADDR;
      cnt_nxt    = '0;
      sda_oe_nxt = 1'b0;
    end
    if (bus_stop) begin
      state_nxt  = ST_IDLE;
      cnt_nxt    = '0;
      sda_oe_nxt = 1'b0;
      busy_nxt   = 1'b0;
    end
  end

  // The bank is updated at the end of the strobe cycle, so a same-index fabric read sees the old value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      writeStrobe <= 1'b0;
      writeAddr   <= '0;
      writeData   <= '0;
      for (int i = 0; i < regCount; i++) begin
        reg_bank[i] <= 8'h00;
      end
    end else begin
      writeStrobe <= wr_en;
      if (wr_en) begin
        writeAddr <= ptr;
        writeData <= rx_byte;
      end
      if (writeStrobe) begin
        reg_bank[writeAddr] <= writeData;
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_responder.sv
// Bench for i2c_target_responder: bit-banged I2C initiator against a register-bank reference model.
module tb_i2c_target_responder;

  localparam int T = 8;

  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_low;
  logic       sda_low;
  wire        SCL;
  wire        SDA;
  logic [3:0] regSel;
  logic [7:0] regValue;
  logic       writeStrobe;
  logic [3:0] writeAddr;
  logic [7:0] writeData;
  logic       busy;

  int         n_cmp = 0;
  int         n_fail = 0;

  logic [7:0] model_regs [16];
  int         model_ptr;
  logic [3:0] exp_wa_q[$];
  logic [7:0] exp_wd_q[$];
  logic [3:0] got_wa_q[$];
  logic [7:0] got_wd_q[$];

  assign SCL = scl_low ? 1'b0 : 1'bz;
  assign SDA = sda_low ? 1'b0 : 1'bz;
  pullup (SCL);
  pullup (SDA);

  always #5 clk = ~clk;

  i2c_target_responder dut (
    .clk         (clk),
    .reset       (reset),
    .SCL         (SCL),
    .SDA         (SDA),
    .regSel      (regSel),
    .regValue    (regValue),
    .writeStrobe (writeStrobe),
    .writeAddr   (writeAddr),
    .writeData   (writeData),
    .busy        (busy)
  );

  always @(negedge clk) begin
    if (writeStrobe) begin
      got_wa_q.push_back(writeAddr);
      got_wd_q.push_back(writeData);
    end
  end

  // ---------------- reference model ----------------
  task automatic model_write(input logic [7:0] p, input byte_q_t data);
    model_ptr = int'(p) % 16;
    foreach (data[k]) begin
      model_regs[model_ptr] = data[k];
      exp_wa_q.push_back(4'(model_ptr));
      exp_wd_q.push_back(data[k]);
      model_ptr = (model_ptr + 1) % 16;
    end
  endtask

  task automatic model_read(input logic set_ptr, input logic [7:0] p, input int n, output byte_q_t exp);
    exp = {};
    if (set_ptr) model_ptr = int'(p) % 16;
    for (int k = 0; k < n; k++) begin
      exp.push_back(model_regs[model_ptr]);
      model_ptr = (model_ptr + 1) % 16;
    end
  endtask

  task automatic clear_queues();
    exp_wa_q = {};
    exp_wd_q = {};
    got_wa_q = {};
    got_wd_q = {};
  endtask

  // ---------------- bus initiator ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    wait_clks(T); sda_low = 1'b0;
    wait_clks(T); scl_low = 1'b0;
    wait_clks(T); sda_low = 1'b1;
    wait_clks(T); scl_low = 1'b1;
  endtask

  task automatic bus_stop();
    wait_clks(T); sda_low = 1'b1;
    wait_clks(T); scl_low = 1'b0;
    wait_clks(T); sda_low = 1'b0;
    wait_clks(T);
  endtask

  task automatic put_bit(input logic b);
    wait_clks(T); sda_low = ~b;
    wait_clks(T); scl_low = 1'b0;
    wait_clks(2 * T); scl_low = 1'b1;
  endtask

  task automatic get_bit(output logic b);
    wait_clks(T); sda_low = 1'b0;
    wait_clks(T); scl_low = 1'b0;
    wait_clks(T); b = SDA;
    wait_clks(T); scl_low = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic nack);
    logic b;
    d = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(nack);
  endtask

  task automatic do_write(input logic [7:0] p, input byte_q_t data, output int nacks, output logic busy_mid);
    logic a;
    nacks = 0;
    bus_start();
    send_byte(8'h72, a); nacks += int'(a);
    busy_mid = busy;
    send_byte(p, a); nacks += int'(a);
    foreach (data[k]) begin
      send_byte(data[k], a);
      nacks += int'(a);
    end
    bus_stop();
    wait_clks(4);
  endtask

  task automatic do_read(input logic set_ptr, input logic [7:0] p, input int n, output byte_q_t got,
                         output int nacks, output logic sda_after, output logic busy_after);
    logic       a;
    logic [7:0] d;
    nacks = 0;
    got = {};
    bus_start();
    if (set_ptr) begin
      send_byte(8'h72, a); nacks += int'(a);
      send_byte(p, a); nacks += int'(a);
      bus_start();
    end
    send_byte(8'h73, a); nacks += int'(a);
    for (int k = 0; k < n; k++) begin
      recv_byte(d, k == n - 1);
      got.push_back(d);
    end
    wait_clks(T);
    sda_after  = SDA;
    busy_after = busy;
    bus_stop();
    wait_clks(4);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; scl_low = 1'b0; sda_low = 1'b0; regSel = 4'h0;
    for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
    model_ptr = 0;
    wait_clks(3);
    n_cmp++;
    if (SDA !== 1'b1 || busy !== 1'b0 || writeStrobe !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: sda=%b busy=%b strobe=%b, required 1 0 0", SDA, busy, writeStrobe);
    end
    n_cmp++;
    if (writeAddr !== 4'h0 || writeData !== 8'h00) begin
      n_fail++; $display("FAIL reset_write_bus: addr=%h data=%h, required 0 00", writeAddr, writeData);
    end
    reset = 1'b0;
    wait_clks(5);
    for (int i = 0; i < 16; i++) begin
      regSel = 4'(i); #1;
      n_cmp++;
      if (regValue !== 8'h00) begin n_fail++; $display("FAIL reset_bank[%0d]: got %h required 00", i, regValue); end
    end
  endtask

  task automatic test_write_basic();
    int   nacks;
    logic bm;
    clear_queues();
    model_write(8'h03, {8'hA5, 8'h5A});
    do_write(8'h03, {8'hA5, 8'h5A}, nacks, bm);
    n_cmp++;
    if (nacks !== 0) begin n_fail++; $display("FAIL write_acks: got %0d NACKs required 0", nacks); end
    n_cmp++;
    if (bm !== 1'b1) begin n_fail++; $display("FAIL write_busy: got %b required 1", bm); end
    n_cmp++;
    if (got_wa_q.size() !== 2) begin n_fail++; $display("FAIL write_strobes: got %0d required 2", got_wa_q.size()); end
    for (int k = 0; k < exp_wa_q.size() && k < got_wa_q.size(); k++) begin
      n_cmp++;
      if (got_wa_q[k] !== exp_wa_q[k] || got_wd_q[k] !== exp_wd_q[k]) begin
        n_fail++; $display("FAIL write_strobe[%0d]: got %h:%h required %h:%h", k, got_wa_q[k], got_wd_q[k], exp_wa_q[k], exp_wd_q[k]);
      end
    end
    regSel = 4'h3; #1;
    n_cmp++;
    if (regValue !== 8'hA5) begin n_fail++; $display("FAIL write_reg3: got %h required a5", regValue); end
    regSel = 4'h4; #1;
    n_cmp++;
    if (regValue !== 8'h5A) begin n_fail++; $display("FAIL write_reg4: got %h required 5a", regValue); end
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_after_stop: got %b required 0", busy); end
  endtask

  task automatic test_read_repeated_start();
    byte_q_t got, exp;
    int      nacks;
    logic    sa, ba;
    model_read(1'b1, 8'h03, 2, exp);
    do_read(1'b1, 8'h03, 2, got, nacks, sa, ba);
    n_cmp++;
    if (nacks !== 0) begin n_fail++; $display("FAIL read_acks: got %0d NACKs required 0", nacks); end
    n_cmp++;
    if (got.size() !== 2 || got[0] !== 8'hA5 || got[1] !== 8'h5A || got[0] !== exp[0] || got[1] !== exp[1]) begin
      n_fail++; $display("FAIL read_data: got %p required a5 5a", got);
    end
    n_cmp++;
    if (sa !== 1'b1 || ba !== 1'b0) begin n_fail++; $display("FAIL read_release: sda=%b busy=%b required 1 0", sa, ba); end
  endtask

  task automatic test_mismatch();
    logic       a;
    logic [6:0] addr;
    clear_queues();
    for (int it = 0; it < 2; it++) begin
      if (it == 0) begin
        addr = 7'h28;
      end else begin
        do addr = 7'($urandom_range(0, 127)); while (addr == 7'h39);
      end
      bus_start();
      send_byte({addr, it[0]}, a);
      n_cmp++;
      if (a !== 1'b1 || busy !== 1'b0) begin
        n_fail++; $display("FAIL mismatch_addr %h: ack_line=%b busy=%b required 1 0", addr, a, busy);
      end
      for (int k = 0; k < 2; k++) begin
        send_byte(8'($urandom_range(0, 255)), a);
        n_cmp++;
        if (a !== 1'b1 || busy !== 1'b0) begin
          n_fail++; $display("FAIL mismatch_data: ack_line=%b busy=%b required 1 0", a, busy);
        end
      end
      bus_stop();
    end
    n_cmp++;
    if (got_wa_q.size() !== 0) begin n_fail++; $display("FAIL mismatch_strobes: got %0d required 0", got_wa_q.size()); end
    for (int i = 0; i < 16; i++) begin
      regSel = 4'(i); #1;
      n_cmp++;
      if (regValue !== model_regs[i]) begin n_fail++; $display("FAIL mismatch_bank[%0d]: got %h required %h", i, regValue, model_regs[i]); end
    end
  endtask

  task automatic test_wrap();
    byte_q_t got, exp;
    int      nacks;
    logic    bm, sa, ba;
    clear_queues();
    model_write(8'h0F, {8'h11, 8'h22});
    do_write(8'h0F, {8'h11, 8'h22}, nacks, bm);
    n_cmp++;
    if (got_wa_q.size() !== 2 || got_wa_q[0] !== 4'hF || got_wa_q[1] !== 4'h0) begin
      n_fail++; $display("FAIL wrap_strobe_addr: got %p required f 0", got_wa_q);
    end
    regSel = 4'hF; #1;
    n_cmp++;
    if (regValue !== 8'h11) begin n_fail++; $display("FAIL wrap_reg15: got %h required 11", regValue); end
    regSel = 4'h0; #1;
    n_cmp++;
    if (regValue !== 8'h22) begin n_fail++; $display("FAIL wrap_reg0: got %h required 22", regValue); end
    model_read(1'b1, 8'h0F, 2, exp);
    do_read(1'b1, 8'h0F, 2, got, nacks, sa, ba);
    n_cmp++;
    if (got.size() !== 2 || got[0] !== exp[0] || got[1] !== exp[1]) begin
      n_fail++; $display("FAIL wrap_read: got %p required %p", got, exp);
    end
  endtask

  task automatic test_truncation();
    int   nacks;
    logic bm;
    clear_queues();
    model_write(8'h35, {8'hC3});
    do_write(8'h35, {8'hC3}, nacks, bm);
    n_cmp++;
    if (got_wa_q.size() !== 1 || got_wa_q[0] !== 4'h5 || got_wd_q[0] !== 8'hC3) begin
      n_fail++; $display("FAIL trunc_strobe: got %p/%p required 5/c3", got_wa_q, got_wd_q);
    end
    regSel = 4'h5; #1;
    n_cmp++;
    if (regValue !== 8'hC3) begin n_fail++; $display("FAIL trunc_reg5: got %h required c3", regValue); end
  endtask

  task automatic test_abort();
    logic    a, sa, ba;
    byte_q_t got, exp;
    int      nacks;
    clear_queues();
    bus_start();
    send_byte(8'h72, a);
    send_byte(8'h08, a);
    model_ptr = 8;
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b1);
    bus_stop();
    wait_clks(4);
    n_cmp++;
    if (got_wa_q.size() !== 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_state: strobes=%0d busy=%b required 0 0", got_wa_q.size(), busy);
    end
    regSel = 4'h8; #1;
    n_cmp++;
    if (regValue !== model_regs[8]) begin n_fail++; $display("FAIL abort_reg8: got %h required %h", regValue, model_regs[8]); end
    model_read(1'b0, 8'h00, 1, exp);
    do_read(1'b0, 8'h00, 1, got, nacks, sa, ba);
    n_cmp++;
    if (nacks !== 0 || got.size() !== 1 || got[0] !== exp[0]) begin
      n_fail++; $display("FAIL abort_kept_ptr_read: got %p nacks=%0d required %p", got, nacks, exp);
    end
  endtask

  task automatic test_random_bursts();
    byte_q_t     data, got, exp;
    logic [7:0]  p;
    int          nacks;
    logic        bm, sa, ba;
    for (int it = 0; it < 6; it++) begin
      clear_queues();
      data = {};
      p = 8'($urandom_range(0, 255));
      for (int k = 0; k < int'($urandom_range(1, 4)); k++) data.push_back(8'($urandom_range(0, 255)));
      model_write(p, data);
      do_write(p, data, nacks, bm);
      n_cmp++;
      if (nacks !== 0 || got_wa_q.size() !== exp_wa_q.size()) begin
        n_fail++; $display("FAIL rand_write[%0d]: nacks=%0d strobes=%0d required 0 %0d", it, nacks, got_wa_q.size(), exp_wa_q.size());
      end
      for (int k = 0; k < exp_wa_q.size() && k < got_wa_q.size(); k++) begin
        n_cmp++;
        if (got_wa_q[k] !== exp_wa_q[k] || got_wd_q[k] !== exp_wd_q[k]) begin
          n_fail++; $display("FAIL rand_strobe[%0d.%0d]: got %h:%h required %h:%h", it, k, got_wa_q[k], got_wd_q[k], exp_wa_q[k], exp_wd_q[k]);
        end
      end
      p = 8'($urandom_range(0, 255));
      model_read(1'b1, p, int'($urandom_range(1, 4)), exp);
      do_read(1'b1, p, exp.size(), got, nacks, sa, ba);
      n_cmp++;
      if (got != exp || nacks !== 0 || sa !== 1'b1) begin
        n_fail++; $display("FAIL rand_read[%0d] ptr %h: got %p required %p", it, p, got, exp);
      end
    end
    for (int i = 0; i < 16; i++) begin
      regSel = 4'(i); #1;
      n_cmp++;
      if (regValue !== model_regs[i]) begin n_fail++; $display("FAIL rand_bank[%0d]: got %h required %h", i, regValue, model_regs[i]); end
    end
  endtask

  task automatic test_reset_mid_read();
    logic    a, bm, sa, ba;
    int      nacks;
    byte_q_t got, exp;
    clear_queues();
    model_write(8'h06, {8'h0F});
    do_write(8'h06, {8'h0F}, nacks, bm);
    bus_start();
    send_byte(8'h72, a);
    send_byte(8'h06, a);
    bus_start();
    send_byte(8'h73, a);
    wait_clks(T);
    n_cmp++;
    if (SDA !== 1'b0) begin n_fail++; $display("FAIL midread_drive: sda=%b required 0", SDA); end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (SDA !== 1'b1) begin n_fail++; $display("FAIL midread_reset_release: sda=%b required 1", SDA); end
    wait_clks(T);
    scl_low = 1'b0; sda_low = 1'b0;
    wait_clks(T);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
    model_ptr = 0;
    wait_clks(4);
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midread_busy: got %b required 0", busy); end
    for (int i = 0; i < 16; i++) begin
      regSel = 4'(i); #1;
      n_cmp++;
      if (regValue !== 8'h00) begin n_fail++; $display("FAIL midread_bank[%0d]: got %h required 00", i, regValue); end
    end
    model_read(1'b0, 8'h00, 2, exp);
    do_read(1'b0, 8'h00, 2, got, nacks, sa, ba);
    n_cmp++;
    if (got != exp || nacks !== 0) begin n_fail++; $display("FAIL midread_after: got %p required %p", got, exp); end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_repeated_start();
    test_mismatch();
    test_wrap();
    test_truncation();
    test_abort();
    test_random_bursts();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_target_responder.md
Name: i2c_target_responder

Overview:
- I2C target (slave) responder that answers a bus initiator on SCL/SDA at up to 400 kHz and holds a small byte-wide register bank.
- Used as the board-side model and on-chip configuration target for the HDMI overlay design, e.g. for overlay position and enable registers.
- Supports register-pointer writes, auto-incrementing burst writes and burst reads, including repeated START.
- Oversamples the bus with the system clock; never stretches SCL.

Parameters:
- slaveAddress, 7'h39, 7-bit target address matched after START.
- regCount, 16, number of 8-bit registers; must be a power of two, 2..256.
- ptrWidth, 4, log2(regCount); width of the register pointer.

Ports:
- clk  input  1  system clock; must be >= 20x the SCL frequency.
- reset  input  1  asynchronous, active-high reset.
- SCL  inout  1  I2C clock; only ever read, never driven (held Z).
- SDA  inout  1  I2C data, open-drain: driven 0 or Z only, never 1.
- regSel  input  ptrWidth  fabric read select into the register bank.
- regValue  output  8  combinational register[regSel].
- writeStrobe  output  1  one-clk pulse each time the initiator writes a data byte.
- writeAddr  output  ptrWidth  register index of the write; valid with writeStrobe.
- writeData  output  8  data byte written; valid with writeStrobe.
- busy  output  1  high from an address-matched START until STOP, mismatch or NACK-return to IDLE.

Behaviour:
- Reset (async, active-high):
  - All registers = 0x00; pointer = 0.
  - SDA released (Z); state IDLE.
  - writeStrobe = 0, writeAddr = 0, writeData = 0x00, busy = 0.
- Input sampling: SCL and SDA each pass through a 2-FF synchronizer plus one history flop. All edges are detected on the synchronized values.
- Bus conditions:
  - START = SDA falling while SCL high.
  - STOP = SDA rising while SCL high.
  - START in any state (repeated START) -> ADDR with bit counter cleared; the pointer is kept.
  - STOP in any state -> IDLE, SDA released, busy = 0.
- Data bits are sampled on SCL rising, MSB first. SDA is changed by this block only after an SCL falling edge.
- Output latency: the SDA drive change reaches the pin no later than 3 clk after the synchronized SCL falling edge.
- States:
  - IDLE: wait for START.
  - ADDR: shift in 7 address bits + R/W. On the 8th bit, address match -> ADDR_ACK; mismatch -> IGNORE (no ACK, wait for START/STOP).
  - ADDR_ACK: drive SDA low for the 9th clock; busy = 1. R/W=0 -> PTR; R/W=1 -> READ (first byte = register[pointer]).
  - PTR: shift 8 bits; pointer = low ptrWidth bits of the byte (upper bits discarded) -> PTR_ACK (ACK) -> WRITE.
  - WRITE: shift 8 bits -> WRITE_ACK.
    - On the 8th SCL rising edge: register[pointer] = byte; writeStrobe pulses one clk with writeAddr = pointer, writeData = byte.
    - Then pointer = (pointer + 1) mod regCount.
    - ACK, then return to WRITE.
  - READ:
    - On SCL falling after ACK, load the shift register with register[pointer] and drive bits MSB first (0 -> drive low, 1 -> Z).
    - After the 8th bit, release SDA; pointer += 1 mod regCount -> READ_ACK.
  - READ_ACK: sample the initiator on the 9th SCL rising. ACK (0) -> READ next byte; NACK (1) -> IDLE-wait (SDA released, busy = 0, wait for STOP/START).
- ACK timing: SDA held low from the SCL falling edge after bit 8 until the SCL falling edge after bit 9.
- Pointer wrap: 0x0F + 1 -> 0x00 at regCount = 16, for both reads and writes.
- Simultaneous events:
  - If writeStrobe and a fabric regSel read hit the same index in the same clk, regValue shows the old value; the new value appears next clk.
  - A STOP/START seen mid-byte aborts the byte; a partial write byte is never committed.
- Reset mid-transfer releases SDA immediately (asynchronously) and discards all progress.

Test Plan:
- Write to pointer 0x03 at slaveAddress 0x39: START, 0x72, 0x03, 0xA5, 0x5A, STOP -> three ACKs on data; reg[3]=0xA5, reg[4]=0x5A; two writeStrobe pulses with writeAddr 3, 4.
- Read back via repeated START: START, 0x72, 0x03, Sr, 0x73, read 2 bytes (ACK then NACK), STOP -> SDA returns 0xA5 then 0x5A; SDA released after the NACK.
- Address mismatch: START, 0x50 -> no ACK (SDA Z on the 9th clock); subsequent bytes ignored; busy stays 0; registers unchanged.
- Pointer wrap: write pointer 0x0F then data 0x11, 0x22 -> reg[15]=0x11, reg[0]=0x22; a burst read from 0x0F returns 0x11, 0x22.
- Pointer truncation: pointer byte 0x35 with regCount 16 -> write lands in reg[5].
- Abort and reset:
  - STOP after 4 bits of a data byte -> no writeStrobe, register unchanged, IDLE.
  - Asserting reset during a read byte -> SDA Z within the same clk; all registers read 0x00 afterwards.
